// File: rtl/button_pkg.sv
// button_pkg: shared defaults and widths for the button arbiter slice
package button_pkg;
  localparam int NUM_BTN_DEF = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int ID_W = $clog2(NUM_BTN_DEF);
  localparam int CNT_W = 8;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stability counter and rising-edge pulse for one button
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_b,
  output logic o_rise
);
  localparam logic [CNT_W:0] LIM = DEBOUNCE_CYCLES[CNT_W:0];
  logic [1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0] cnt_inc;
  logic stable_q, stable_d, prev_q, prev_d, hit;
  always_comb begin
    sync_d = {sync_q[0], in_b};
    cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    hit = (sync_q[1] != stable_q) && (cnt_inc == LIM);
    cnt_d = (sync_q[1] == stable_q || hit) ? '0 : cnt_inc[CNT_W-1:0];
    stable_d = stable_q ^ hit;
    prev_d = stable_q;
    o_rise = stable_q & ~prev_q;
  end
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      stable_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      stable_q <= stable_d;
      prev_q <= prev_d;
    end
  end
endmodule

// File: rtl/button_arbiter.sv
// button_arbiter: debounced press events arbitrated round-robin into a valid/ready output
module button_arbiter
  import button_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  localparam int IW = $clog2(NUM_BTN)
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic [NUM_BTN-1:0] in_b,
  input  logic               in_ready,
  input  logic               in_ovf_clr,
  output logic               o_valid,
  output logic [IW-1:0]      o_id,
  output logic [NUM_BTN-1:0] o_overflow
);
  logic [NUM_BTN-1:0] rise, clr, pending_q, pending_d, ovf_q, ovf_d;
  logic [IW-1:0] id_q, id_d, last_q, last_d, win, idx;
  logic valid_q, valid_d, free, found, load;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .in_clk(in_clk),
      .in_rst(in_rst),
      .in_b(in_b[i]),
      .o_rise(rise[i])
    );
  end
  always_comb begin
    free = ~valid_q | in_ready;
    win = '0;
    idx = '0;
    found = 1'b0;
    // scan farthest-first so the candidate nearest last_grant+1 is the last to overwrite
    for (int k = NUM_BTN; k >= 1; k--) begin
      idx = IW'((32'(last_q) + k) % NUM_BTN);
      if (pending_q[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    load = free & found;
    clr = load ? (NUM_BTN'(1) << win) : '0;
    pending_d = (pending_q & ~clr) | rise;
    ovf_d = (in_ovf_clr ? '0 : ovf_q) | (rise & pending_q & ~clr);
    valid_d = free ? found : valid_q;
    id_d = load ? win : id_q;
    last_d = load ? win : last_q;
  end
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      pending_q <= '0;
      ovf_q <= '0;
      valid_q <= 1'b0;
      id_q <= '0;
      last_q <= IW'(NUM_BTN - 1);
    end else begin
      pending_q <= pending_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
      id_q <= id_d;
      last_q <= last_d;
    end
  end
  assign o_valid = valid_q;
  assign o_id = id_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_button_arbiter.sv
// tb_button_arbiter: scoreboard bench with a behavioural model of debounce and round-robin delivery
module tb_button_arbiter;
  localparam int N = 4;
  localparam int DEB = 4;
  logic in_clk = 1'b0, in_rst = 1'b1, in_ready = 1'b0, in_ovf_clr = 1'b0;
  logic [N-1:0] in_b = '0;
  logic o_valid;
  logic [1:0] o_id;
  logic [N-1:0] o_overflow;
  int checks = 0, failures = 0, delivered = 0, lat;
  int exp_q[$];
  int got_q[$];
  logic [1:0] m_sh[N];
  bit m_stable[N];
  bit m_rise[N];
  int m_run[N];
  bit [N-1:0] m_pend, m_ovf;
  bit m_valid;
  int m_last;

  button_arbiter #(.NUM_BTN(N), .DEBOUNCE_CYCLES(DEB)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_b(in_b), .in_ready(in_ready),
    .in_ovf_clr(in_ovf_clr), .o_valid(o_valid), .o_id(o_id), .o_overflow(o_overflow)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge in_clk);
    #2;
  endtask

  // Reference: a level change is accepted after DEB consecutive differing samples of the
  // 2-cycle-delayed input; accepted presses queue per button and are served round-robin.
  always @(posedge in_clk or posedge in_rst) begin : model
    bit free, level;
    int win;
    bit [N-1:0] clr, set;
    if (in_rst) begin
      for (int i = 0; i < N; i++) begin
        m_sh[i] = 2'b00; m_stable[i] = 0; m_rise[i] = 0; m_run[i] = 0;
      end
      m_pend = '0; m_ovf = '0; m_valid = 0; m_last = N - 1;
      exp_q.delete();
    end else begin
      free = !m_valid || in_ready;
      win = -1;
      for (int k = 1; k <= N; k++)
        if (win < 0 && m_pend[(m_last + k) % N]) win = (m_last + k) % N;
      clr = '0;
      if (free && win >= 0) clr[win] = 1'b1;
      for (int i = 0; i < N; i++) set[i] = m_rise[i];
      m_ovf = (in_ovf_clr ? '0 : m_ovf) | (set & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | set;
      if (free) begin
        m_valid = (win >= 0);
        if (win >= 0) begin
          m_last = win;
          exp_q.push_back(win);
        end
      end
      for (int i = 0; i < N; i++) begin
        m_rise[i] = 0;
        level = m_sh[i][1];
        if (level != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stable[i] = !m_stable[i];
            m_run[i] = 0;
            m_rise[i] = m_stable[i];
          end
        end else m_run[i] = 0;
        m_sh[i] = {m_sh[i][0], in_b[i]};
      end
    end
  end

  always @(negedge in_clk) begin
    chk("valid", int'(o_valid), int'(m_valid));
    chk("overflow", int'(o_overflow), int'(m_ovf));
    if (!in_rst && o_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual_id=%0d required=none at %0t", o_id, $time);
      end else if (in_ready) begin
        got_q.push_back(int'(o_id));
        delivered++;
        chk("event_id", int'(o_id), exp_q.pop_front());
      end else chk("hold_id", int'(o_id), exp_q[0]);
    end
  end

  initial begin
    step(2);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_id", int'(o_id), 0);
    chk("rst_ovf", int'(o_overflow), 0);
    in_rst = 0;
    step(2);
    in_ready = 1;
    in_b = 4'b0001;
    lat = 0;
    for (int c = 0; c < 20 && !o_valid; c++) begin
      @(posedge in_clk);
      lat++;
      #1;
    end
    #1;
    chk("press_latency", lat, 8);
    step(2);
    in_b = '0;
    step(12);
    for (int t = 0; t < 6; t++) begin
      in_b[1] = ~in_b[1];
      step(2);
    end
    in_b[1] = 1;
    step(15);
    in_b = '0;
    step(15);
    chk("bounce_single_event", got_q.size(), 2);
    in_rst = 1;
    step(1);
    in_rst = 0;
    got_q.delete();
    step(2);
    for (int r = 0; r < 2; r++) begin
      in_b = 4'hF;
      step(12);
      in_b = '0;
      step(12);
    end
    chk("rr_count", got_q.size(), 8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) chk("rr_seq", got_q[k], k % 4);
    in_ready = 0;
    in_b = 4'b0100;
    step(12);
    in_b = '0;
    step(20);
    chk("bp_valid", int'(o_valid), 1);
    chk("bp_id", int'(o_id), 2);
    in_ready = 1;
    step(1);
    chk("bp_release", int'(o_valid), 0);
    step(4);
    in_ready = 0;
    for (int p = 0; p < 3; p++) begin
      in_b[3] = 1;
      step(8);
      in_b[3] = 0;
      step(8);
    end
    chk("ovf_set", int'(o_overflow), 8);
    in_ovf_clr = 1;
    step(1);
    in_ovf_clr = 0;
    chk("ovf_clr", int'(o_overflow), 0);
    in_ready = 1;
    step(6);
    in_ready = 0;
    in_b = 4'b0111;
    step(12);
    in_b = '0;
    chk("pre_rst_valid", int'(o_valid), 1);
    in_rst = 1;
    #1;
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_id", int'(o_id), 0);
    chk("mid_rst_ovf", int'(o_overflow), 0);
    step(2);
    in_rst = 0;
    in_ready = 1;
    got_q.delete();
    step(20);
    chk("no_stale_event", got_q.size(), 0);
    in_rst = 1;
    in_b = 4'b0001;
    step(3);
    in_rst = 0;
    step(15);
    in_b = '0;
    step(12);
    chk("held_through_reset", got_q.size(), 1);
    repeat (1500) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) in_b[i] = ~in_b[i];
      in_ready = ($urandom_range(0, 3) != 0);
      in_ovf_clr = ($urandom_range(0, 40) == 0);
      step(1);
    end
    in_b = '0;
    in_ready = 1;
    in_ovf_clr = 0;
    step(30);
    chk("queue_drained", exp_q.size(), 0);
    chk("events_delivered", int'(delivered > 20), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_arbiter.md
BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 Parameter NUM_BTN, default 4, number of button inputs (2..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles before a level change is accepted (1..255).
REQ-003 in_clk  input  1  single clock; all state updates on rising edge.
REQ-004 in_rst  input  1  reset, asynchronous, active-high.
REQ-005 in_b  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
REQ-006 in_ready  input  1  consumer accepts the event when high with o_valid high.
REQ-007 in_ovf_clr  input  1  synchronous clear of all o_overflow bits.
REQ-008 o_valid  output  1  registered event-valid.
REQ-009 o_id  output  clog2(NUM_BTN)  index of pressed button; valid only when o_valid is high.
REQ-010 o_overflow  output  NUM_BTN  sticky per-button lost-event flags.

Function
REQ-011 Each in_b bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per button, a debounce counter SHALL count cycles in which the synchronized level differs from the stable level; it resets to 0 whenever they are equal.
REQ-013 Stable level SHALL toggle on the edge at which the counter reaches DEBOUNCE_CYCLES; the counter then returns to 0.
REQ-014 A 0->1 transition of the stable level SHALL set pending[i] on the next edge; 1->0 transitions generate no event.
REQ-015 Isolated-press latency, output idle: in_b[i] sampled high at edge 1 -> o_valid high after edge 2+DEBOUNCE_CYCLES+2 (edge 8 at default).
REQ-016 The output register is "free" when o_valid=0 or (o_valid=1 and in_ready=1); when free and any pending bit is set, it SHALL load the round-robin winner, set o_valid=1, and clear that pending bit on the same edge.
REQ-017 Round-robin: search starts at last_grant+1 modulo NUM_BTN; last_grant updates to the loaded index.
REQ-018 When free and no pending bit is set, o_valid SHALL go to 0.
REQ-019 While o_valid=1 and in_ready=0, o_valid and o_id SHALL hold unchanged.
REQ-020 Back-to-back: with in_ready held high and events pending, o_valid SHALL stay high and deliver one event per cycle.
REQ-021 A new press on button i while pending[i]=1 SHALL leave pending[i]=1 and set o_overflow[i].
REQ-022 A new press on button i in the same cycle pending[i] is being cleared by a load SHALL leave pending[i]=1 and SHALL NOT set o_overflow[i].
REQ-023 in_ovf_clr=1 SHALL clear all o_overflow bits; a simultaneous overflow event SHALL win (bit ends 1).
REQ-024 An event held in the output register SHALL NOT be counted as pending for overflow purposes.

Reset
REQ-025 While in_rst=1: o_valid=0, o_id=0, o_overflow=0, all pending=0, synchronizers=0, stable levels=0, counters=0.
REQ-026 last_grant SHALL reset to NUM_BTN-1, so button 0 wins the first arbitration.
REQ-027 A button held pressed through reset release SHALL generate exactly one event after the normal debounce latency.
REQ-028 Reset asserted mid-handshake SHALL drop o_valid immediately and discard all pending events.

Structure
REQ-029 Package button_pkg SHALL hold the NUM_BTN and DEBOUNCE_CYCLES defaults, ID_W = clog2(NUM_BTN), and the debounce counter width.
REQ-030 Sub-module button_debounce (synchronizer + counter + stable level + rising-edge pulse) SHALL be instantiated NUM_BTN times; arbitration and output logic live in button_arbiter.

Verification
REQ-031 Single press: in_b=0001 held 10 cycles, in_ready=1 -> one o_valid pulse, o_id=0, at edge 8 after first sampling.
REQ-032 Bounce: in_b[1] toggles every 2 cycles for 12 cycles, then held high -> exactly one event, o_id=1, none during bouncing.
REQ-033 Simultaneous presses: in_b=1111 at once, in_ready=1 -> o_id sequence 0,1,2,3 on consecutive cycles; a repeat gives 0,1,2,3 again.
REQ-034 Backpressure: in_ready=0 with event o_id=2 -> o_valid/o_id stable for 20 cycles; in_ready=1 -> accepted, o_valid=0 next edge.
REQ-035 Overflow: in_ready=0, button 3 pressed twice with pending[3] set -> o_overflow=1000; in_ovf_clr pulse -> o_overflow=0000.
REQ-036 Reset mid-operation: in_rst pulsed while o_valid=1 with 2 pending -> all outputs 0 immediately; no stale event after release.
